// File: rtl/pid_ctrl.sv
// Sequential PID controller: one shared multiplier, one product per cycle
// (P, I, D), then a scale/clamp stage and a held result until downstream accepts.
module pid_ctrl #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int FRAC_W = 4,
  parameter int INT_W  = 16,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] target,
  input  logic signed [DATA_W-1:0] current,
  input  logic        [COEF_W-1:0] kp,
  input  logic        [COEF_W-1:0] ki,
  input  logic        [COEF_W-1:0] kd,
  input  logic                     int_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out,
  output logic                     sat,
  output logic                     int_sat
);

  localparam int E_W   = DATA_W + 1;
  localparam int D_W   = DATA_W + 2;
  localparam int ACC_W = COEF_W + INT_W + 2;
  localparam int P_W   = COEF_W + INT_W + 1;

  localparam logic signed [INT_W:0]   INT_MAX = (INT_W+1)'(2**(INT_W-1) - 1);
  localparam logic signed [INT_W:0]   INT_MIN = -((INT_W+1)'(2**(INT_W-1)));
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -(ACC_W'(2**(OUT_W-1)));

  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, SUM, HOLD} state_t;
  state_t state;

  logic        [COEF_W-1:0] kp_q, ki_q, kd_q;
  logic signed [E_W-1:0]    e_q, prev_e;
  logic signed [D_W-1:0]    d_q;
  logic signed [INT_W-1:0]  integral;
  logic signed [ACC_W-1:0]  acc;
  logic                     int_sat_pend;

  // Accept-time arithmetic; int_clr in the same cycle zeroes the history first.
  logic signed [E_W-1:0]   e_new, pe_base;
  logic signed [D_W-1:0]   d_new;
  logic signed [INT_W-1:0] i_base;
  logic signed [INT_W:0]   i_sum;
  logic signed [INT_W-1:0] i_clamped;
  logic                    i_clip;

  always_comb begin
    e_new     = E_W'(target) - E_W'(current);
    pe_base   = int_clr ? '0 : prev_e;
    i_base    = int_clr ? '0 : integral;
    d_new     = D_W'(e_new) - D_W'(pe_base);
    i_sum     = (INT_W+1)'(i_base) + (INT_W+1)'(e_new);
    i_clip    = 1'b0;
    i_clamped = i_sum[INT_W-1:0];
    if (i_sum > INT_MAX) begin
      i_clamped = INT_MAX[INT_W-1:0];
      i_clip    = 1'b1;
    end else if (i_sum < INT_MIN) begin
      i_clamped = INT_MIN[INT_W-1:0];
      i_clip    = 1'b1;
    end
  end

  // Shared multiplier: coefficient is unsigned, so widen with a zero sign bit.
  logic        [COEF_W-1:0] mul_coef;
  logic signed [INT_W-1:0]  mul_opnd;
  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;

  always_comb begin
    mul_coef = '0;
    mul_opnd = '0;
    case (state)
      MUL_P: begin mul_coef = kp_q; mul_opnd = INT_W'(e_q);  end
      MUL_I: begin mul_coef = ki_q; mul_opnd = integral;     end
      MUL_D: begin mul_coef = kd_q; mul_opnd = INT_W'(d_q);  end
      default: ;
    endcase
    prod     = $signed({1'b0, mul_coef}) * mul_opnd;
    prod_ext = ACC_W'(prod);
  end

  logic signed [ACC_W-1:0] r_full;
  assign r_full    = acc >>> FRAC_W;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      e_q          <= '0;
      d_q          <= '0;
      prev_e       <= '0;
      integral     <= '0;
      acc          <= '0;
      int_sat_pend <= 1'b0;
      out          <= '0;
      sat          <= 1'b0;
      int_sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            kp_q         <= kp;
            ki_q         <= ki;
            kd_q         <= kd;
            e_q          <= e_new;
            d_q          <= d_new;
            prev_e       <= e_new;
            integral     <= i_clamped;
            int_sat_pend <= i_clip;
            state        <= MUL_P;
          end else if (int_clr) begin
            integral <= '0;
            prev_e   <= '0;
          end
        end
        MUL_P: begin acc <= prod_ext;       state <= MUL_I; end
        MUL_I: begin acc <= acc + prod_ext; state <= MUL_D; end
        MUL_D: begin acc <= acc + prod_ext; state <= SUM;   end
        SUM: begin
          if (r_full > OUT_MAX) begin
            out <= OUT_MAX[OUT_W-1:0];
            sat <= 1'b1;
          end else if (r_full < OUT_MIN) begin
            out <= OUT_MIN[OUT_W-1:0];
            sat <= 1'b1;
          end else begin
            out <= r_full[OUT_W-1:0];
            sat <= 1'b0;
          end
          int_sat <= int_sat_pend;
          state   <= HOLD;
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_ctrl.sv
// Self-checking bench for pid_ctrl: directed scenarios plus randomized samples
// compared against an arithmetic reference model of the control law.
module tb_pid_ctrl;

  localparam int OMAX = 32767, OMIN = -32768;
  localparam int IMAX = 32767, IMIN = -32768;

  logic clk = 0, reset = 0, in_valid = 0, int_clr = 0, out_ready = 0;
  logic in_ready, out_valid, sat, int_sat;
  logic signed [7:0] target = 0, current = 0;
  logic [7:0] kp = 0, ki = 0, kd = 0;
  logic signed [15:0] out;

  int checks = 0, errors = 0, cyc = 0;
  longint m_int = 0, m_pe = 0;

  pid_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .target(target), .current(current), .kp(kp), .ki(ki), .kd(kd),
    .int_clr(int_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .sat(sat), .int_sat(int_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if (a < 0 && q * b != a) q = q - 1;
    return q;
  endfunction

  // Reference: PID law with clamped integrator and clamped, floor-scaled output.
  task automatic model_step(input int t, c, gp, gi, gd, input bit clr,
                            output longint o, output bit s, output bit is);
    longint e, d, sum, acc, r;
    if (clr) begin m_int = 0; m_pe = 0; end
    e = t - c;
    d = e - m_pe;
    m_pe = e;
    sum = m_int + e;
    is = 0;
    if (sum > IMAX) begin sum = IMAX; is = 1; end
    else if (sum < IMIN) begin sum = IMIN; is = 1; end
    m_int = sum;
    acc = gp * e + gi * m_int + gd * d;
    r = floor_div(acc, 16);
    s = 0;
    o = r;
    if (r > OMAX) begin o = OMAX; s = 1; end
    else if (r < OMIN) begin o = OMIN; s = 1; end
  endtask

  // Offer one sample, scramble inputs after accept, wait for the result (left in HOLD).
  task automatic send(input int t, c, gp, gi, gd, input bit clr, output int lat,
                      output logic [15:0] o, output logic s, output logic is);
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    target = 8'(t); current = 8'(c); kp = 8'(gp); ki = 8'(gi); kd = 8'(gd);
    int_clr = clr; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; int_clr = 0;
    target = 8'($urandom); current = 8'($urandom);
    kp = 8'($urandom); ki = 8'($urandom); kd = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    o = out; s = sat; is = int_sat;
  endtask

  task automatic ack();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_int = 0; m_pe = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out !== 16'sd0) begin errors++; $display("FAIL reset_out got %0d want 0", out); end
    checks++; if (sat !== 1'b0 || int_sat !== 1'b0) begin errors++; $display("FAIL reset_flags got sat=%b int_sat=%b want 0/0", sat, int_sat); end
  endtask

  task automatic test_prop();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    model_step(10, 4, 16, 0, 0, 0, eo, es, eis);
    send(10, 4, 16, 0, 0, 0, lat, o, s, is);
    checks++; if (lat !== 4) begin errors++; $display("FAIL prop_latency got %0d want 4", lat); end
    checks++; if (o !== 16'(6) || o !== 16'(eo)) begin errors++; $display("FAIL prop_out got %0d want 6", $signed(o)); end
    checks++; if (s !== 1'b0 || is !== 1'b0) begin errors++; $display("FAIL prop_flags got %b/%b want 0/0", s, is); end
    ack();
  endtask

  task automatic test_deriv();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    model_step(6, 0, 0, 0, 16, 1, eo, es, eis);
    send(6, 0, 0, 0, 16, 1, lat, o, s, is);
    checks++; if (o !== 16'(6)) begin errors++; $display("FAIL deriv_first got %0d want 6", $signed(o)); end
    ack();
    model_step(2, 0, 0, 0, 16, 0, eo, es, eis);
    send(2, 0, 0, 0, 16, 0, lat, o, s, is);
    checks++; if (o !== 16'(-4) || o !== 16'(eo)) begin errors++; $display("FAIL deriv_second got %0d want -4", $signed(o)); end
    ack();
  endtask

  task automatic test_int_sat();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    int bad = 0;
    for (int n = 1; n <= 328; n++) begin
      model_step(100, 0, 0, 16, 0, n == 1, eo, es, eis);
      send(100, 0, 0, 16, 0, n == 1, lat, o, s, is);
      if (o !== 16'(eo) || is !== eis || s !== es) bad++;
      ack();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL int_ramp got %0d bad samples want 0", bad); end
    checks++; if (o !== 16'(32767) || is !== 1'b1 || s !== 1'b0) begin
      errors++; $display("FAIL int_sat_328 got out=%0d int_sat=%b sat=%b want 32767/1/0", $signed(o), is, s); end
    model_step(100, 0, 0, 255, 0, 0, eo, es, eis);
    send(100, 0, 0, 255, 0, 0, lat, o, s, is);
    checks++; if (o !== 16'(32767) || s !== 1'b1 || is !== 1'b1) begin
      errors++; $display("FAIL out_sat_hi got out=%0d sat=%b int_sat=%b want 32767/1/1", $signed(o), s, is); end
    ack();
  endtask

  task automatic test_floor();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    model_step(-128, 127, 255, 0, 0, 1, eo, es, eis);
    send(-128, 127, 255, 0, 0, 1, lat, o, s, is);
    checks++; if (o !== 16'(-4065) || s !== 1'b0) begin errors++; $display("FAIL floor_neg got %0d sat=%b want -4065/0", $signed(o), s); end
    ack();
  endtask

  task automatic test_hold_stall();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    int bad = 0;
    model_step(40, -20, 16, 16, 16, 0, eo, es, eis);
    send(40, -20, 16, 16, 16, 0, lat, o, s, is);
    checks++; if (o !== 16'(eo)) begin errors++; $display("FAIL stall_out got %0d want %0d", $signed(o), eo); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; target = 8'($urandom); current = 8'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out !== o || in_ready !== 1'b0 || sat !== s || int_sat !== is) bad++;
    end
    in_valid = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    ack();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    // integrator history must be untouched by the ignored offers
    model_step(3, 1, 16, 16, 16, 0, eo, es, eis);
    send(3, 1, 16, 16, 16, 0, lat, o, s, is);
    checks++; if (o !== 16'(eo)) begin errors++; $display("FAIL stall_no_accept got %0d want %0d", $signed(o), eo); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    int c0, c1;
    model_step(5, 0, 32, 0, 0, 0, eo, es, eis);
    c0 = cyc;
    send(5, 0, 32, 0, 0, 0, lat, o, s, is);
    ack();
    model_step(7, 0, 32, 0, 0, 0, eo, es, eis);
    c1 = cyc;
    send(7, 0, 32, 0, 0, 0, lat, o, s, is);
    checks++; if (c1 - c0 !== 6) begin errors++; $display("FAIL b2b_spacing got %0d want 6", c1 - c0); end
    checks++; if (o !== 16'(eo)) begin errors++; $display("FAIL b2b_out got %0d want %0d", $signed(o), eo); end
    ack();
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    int seen = 0;
    target = 8'sd50; current = 8'sd0; kp = 8'd16; ki = 8'd16; kd = 8'd16; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    m_int = 0; m_pe = 0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_output got %0d valid cycles want 0", seen); end
    model_step(5, 0, 0, 16, 16, 0, eo, es, eis);
    send(5, 0, 0, 16, 16, 0, lat, o, s, is);
    checks++; if (o !== 16'(10) || o !== 16'(eo)) begin errors++; $display("FAIL midreset_history got %0d want 10", $signed(o)); end
    ack();
  endtask

  task automatic test_random();
    int lat; logic [15:0] o; logic s, is; longint eo; bit es, eis;
    int t, c, gp, gi, gd; bit clr;
    for (int n = 0; n < 80; n++) begin
      t = $signed(8'($urandom)); c = $signed(8'($urandom));
      gp = $urandom_range(0, 255); gi = $urandom_range(0, 255); gd = $urandom_range(0, 255);
      clr = ($urandom_range(0, 7) == 0);
      model_step(t, c, gp, gi, gd, clr, eo, es, eis);
      send(t, c, gp, gi, gd, clr, lat, o, s, is);
      checks++;
      if (lat !== 4 || o !== 16'(eo) || s !== es || is !== eis) begin
        errors++;
        $display("FAIL random_%0d got lat=%0d out=%0d sat=%b int_sat=%b want 4/%0d/%b/%b",
                 n, lat, $signed(o), s, is, eo, es, eis);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 ack();
    end
  endtask

  initial begin
    test_reset();
    test_prop();
    test_deriv();
    test_int_sat();
    test_floor();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_ctrl.md
PID_CTRL -- requirements
Module: pid_ctrl

Interface
REQ-001 Parameter DATA_W, 8, width of target/current, signed two's complement.
REQ-002 Parameter COEF_W, 8, width of kp/ki/kd, unsigned.
REQ-003 Parameter FRAC_W, 4, fractional bits of gains (gain 2^FRAC_W = 1.0).
REQ-004 Parameter INT_W, 16, integrator width, signed.
REQ-005 Parameter OUT_W, 16, output width, signed.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock, all state on rising edge.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 in_valid  input  1  sample offered.
REQ-010 in_ready  output  1  block can accept a sample.
REQ-011 target  input  DATA_W  setpoint, signed.
REQ-012 current  input  DATA_W  measurement, signed.
REQ-013 kp, ki, kd  input  COEF_W each  gains, unsigned fixed-point.
REQ-014 int_clr  input  1  clear integrator and previous error.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out  output  OUT_W  control output, signed.
REQ-018 sat  output  1  out was clamped for this sample.
REQ-019 int_sat  output  1  integrator was clamped for this sample.

Function
REQ-020 FSM states IDLE, MUL_P, MUL_I, MUL_D, SUM, HOLD; in_ready = 1 only in IDLE.
REQ-021 Accept = in_valid && in_ready; on accept: latch gains, e = target - current in DATA_W+1 signed bits (no wrap), go MUL_P.
REQ-022 On accept: d = e - prev_e (DATA_W+2 signed bits) latched; prev_e <= e.
REQ-023 On accept: integral <= clamp(integral + e) to [-2^(INT_W-1), 2^(INT_W-1)-1]; int_sat <= 1 iff clamped.
REQ-024 One shared multiplier, one product per cycle: MUL_P acc = kp*e; MUL_I acc += ki*integral (updated value); MUL_D acc += kd*d.
REQ-025 Accumulator width ≥ COEF_W+INT_W+2; accumulator never overflows.
REQ-026 SUM: r = acc >>> FRAC_W (arithmetic, floor); out <= clamp(r) to OUT_W signed range; sat <= 1 iff clamped; go HOLD.
REQ-027 HOLD: out_valid = 1; out, sat, int_sat stable until out_valid && out_ready, then IDLE.
REQ-028 Latency: out_valid high after 4th rising edge following accepting edge; max throughput one sample per 6 cycles.
REQ-029 in_valid while not IDLE ignored; gain/input changes after accept do not affect in-flight sample.
REQ-030 int_clr sampled only in IDLE: integral <= 0, prev_e <= 0; ignored in other states.
REQ-031 int_clr coincident with accept: accept uses integral = 0, prev_e = 0, so integral <= clamp(e), d = e.
REQ-032 out, sat, int_sat retain last values outside HOLD; out_valid = 0 outside HOLD.

Reset
REQ-033 reset at any state, including mid-computation: next state IDLE, in-flight sample discarded, no out_valid pulse.
REQ-034 Reset values: out = 0, out_valid = 0, sat = 0, int_sat = 0, integral = 0, prev_e = 0, acc = 0; in_ready = 1 after reset edge.
REQ-035 reset has priority over accept and int_clr.

Verification (defaults)
REQ-036 Reset; target=10, current=4, kp=16, ki=0, kd=0 -> out=6 after 4 edges, sat=0, int_sat=0.
REQ-037 kp=ki=0, kd=16; samples e=6 then e=2 -> out=6 then out=-4.
REQ-038 ki=16, kp=kd=0, e=100 repeated -> 328th sample: integral=32767, int_sat=1, out=32767, sat=0.
REQ-039 int_clr then target=-128, current=127, kp=255, ki=kd=0 -> out=-4065 (floor), sat=0; then ki=255 with integral=32767 -> out=32767, sat=1.
REQ-040 out_ready low 10 cycles in HOLD with in_valid pulsing -> out/out_valid stable, in_ready=0, no sample accepted; release -> IDLE next cycle.
REQ-041 reset asserted in MUL_I -> next cycle in_ready=1, out_valid=0, integral=0, no output for discarded sample.
